// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_t : sequencer state encoding
//   CNT_W()     : width of a counter that must hold values 0..val
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  function automatic int CNT_W(input int val);
    return (val < 1) ? 1 : $clog2(val + 1);
  endfunction

endpackage

// File: rtl/red_pitaya_sync2.sv
// Two-flop synchronizer with a parameterized reset value.
//   clk_i  : destination clock
//   rstn_i : asynchronous active-low reset, loads RST_VAL into both flops
//   d_i    : asynchronous input
//   q_o    : synchronized output
module red_pitaya_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/red_pitaya_rst_seq.sv
// Power-on / run-time reset sequencer. Waits for a filtered PLL lock, then
// releases STAGES active-low domain resets one at a time, HOLD_CYC clocks
// apart. Lock loss or a software reset pulls every stage back at once.
//   clk_i       : sequencer clock
//   rstn_i      : global reset, async assert, active-low
//   pll_lock_i  : PLL lock, asynchronous to clk_i
//   sw_rst_i    : software reset request, one-cycle pulse on clk_i
//   rstn_o      : domain resets, bit 0 released first (registered)
//   ready_o     : all stages released
//   lock_lost_o : sticky lock-loss flag, cleared by rstn_i or sw_rst_i
//
// state     | meaning
// ----------+---------------------------------------------------------
// RESET     | waiting for the synchronized deassertion of rstn_i
// WAIT_LOCK | all stages held; counting consecutive lock_s cycles
// RELEASE   | releasing stages, one every HOLD_CYC clocks
// RUN       | all stages released, watching for lock loss / sw reset
module red_pitaya_rst_seq
  import rst_seq_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int HOLD_CYC  = 16,
  parameter int LOCK_FILT = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              pll_lock_i,
  input  logic              sw_rst_i,
  output logic [STAGES-1:0] rstn_o,
  output logic              ready_o,
  output logic              lock_lost_o
);

  localparam int FCNT_W = CNT_W(LOCK_FILT);
  localparam int HCNT_W = CNT_W(HOLD_CYC);
  localparam int STG_W  = CNT_W(STAGES);

  logic              rst_s;
  logic              lock_s;
  seq_state_t        state;
  logic [FCNT_W-1:0] fcnt;
  logic [HCNT_W-1:0] hcnt;
  logic [STG_W-1:0]  stage;

  red_pitaya_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (1'b1),
    .q_o    (rst_s)
  );

  red_pitaya_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= RESET;
      fcnt        <= '0;
      hcnt        <= '0;
      stage       <= '0;
      rstn_o      <= '0;
      ready_o     <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          if (sw_rst_i) lock_lost_o <= 1'b0;
          if (rst_s)    state       <= WAIT_LOCK;
        end

        WAIT_LOCK: begin
          if (sw_rst_i) lock_lost_o <= 1'b0;
          if (!lock_s) begin
            // any low sample restarts the filter
            fcnt <= '0;
          end else if (fcnt == FCNT_W'(LOCK_FILT - 1)) begin
            state <= RELEASE;
            fcnt  <= '0;
            hcnt  <= '0;
            stage <= '0;
          end else if (fcnt != '1) begin
            fcnt <= fcnt + FCNT_W'(1);
          end
        end

        RELEASE, RUN: begin
          // lock loss is checked first so it wins over a coincident sw reset
          if (!lock_s || sw_rst_i) begin
            state       <= WAIT_LOCK;
            fcnt        <= '0;
            hcnt        <= '0;
            stage       <= '0;
            rstn_o      <= '0;
            ready_o     <= 1'b0;
            lock_lost_o <= !lock_s;
          end else if (state == RELEASE) begin
            if (hcnt == HCNT_W'(HOLD_CYC - 1)) begin
              rstn_o <= rstn_o | (STAGES'(1) << stage);
              hcnt   <= '0;
              if (stage != '1) stage <= stage + STG_W'(1);
              if (stage == STG_W'(STAGES - 1)) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end
            end else if (hcnt != '1) begin
              hcnt <= hcnt + HCNT_W'(1);
            end
          end
        end

        default: state <= RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_rst_seq.sv
module tb_red_pitaya_rst_seq;

  localparam int STAGES    = 3;
  localparam int HOLD_CYC  = 16;
  localparam int LOCK_FILT = 8;
  localparam logic [STAGES-1:0] ALL = '1;

  logic              clk_i;
  logic              rstn_i;
  logic              pll_lock_i;
  logic              sw_rst_i;
  logic [STAGES-1:0] rstn_o;
  logic              ready_o;
  logic              lock_lost_o;

  int checks = 0;
  int fails  = 0;

  red_pitaya_rst_seq #(
    .STAGES    (STAGES),
    .HOLD_CYC  (HOLD_CYC),
    .LOCK_FILT (LOCK_FILT)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .pll_lock_i  (pll_lock_i),
    .sw_rst_i    (sw_rst_i),
    .rstn_o      (rstn_o),
    .ready_o     (ready_o),
    .lock_lost_o (lock_lost_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: if WAIT_LOCK is entered on edge wl with the synchronized lock
  // high from then on, stage k is released on edge wl + LOCK_FILT + (k+1)*HOLD_CYC.
  function automatic logic [STAGES-1:0] exp_mask(input int e, input int wl);
    logic [STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < STAGES; k++)
      if (e >= wl + LOCK_FILT + (k + 1) * HOLD_CYC) m[k] = 1'b1;
    return m;
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // after this returns, the next edge is edge 0 with rstn_i high
  task automatic do_reset_release;
    rstn_i     = 1'b0;
    sw_rst_i   = 1'b0;
    pll_lock_i = 1'b1;
    repeat (3) tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pll_lock_i = 1'($urandom_range(0, 1));
      sw_rst_i   = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (rstn_o !== '0) begin
        fails++; $display("FAIL reset_rstn cyc=%0d got=%b exp=%b", i, rstn_o, {STAGES{1'b0}});
      end
      checks++;
      if (ready_o !== 1'b0) begin
        fails++; $display("FAIL reset_ready cyc=%0d got=%b exp=0", i, ready_o);
      end
      checks++;
      if (lock_lost_o !== 1'b0) begin
        fails++; $display("FAIL reset_lock_lost cyc=%0d got=%b exp=0", i, lock_lost_o);
      end
    end
    sw_rst_i   = 1'b0;
    pll_lock_i = 1'b1;
  endtask

  task automatic test_cold_start;
    logic [STAGES-1:0] m;
    do_reset_release();
    for (int e = 0; e <= 2 + LOCK_FILT + STAGES * HOLD_CYC + 4; e++) begin
      tick();
      m = exp_mask(e, 2);
      checks++;
      if (rstn_o !== m) begin
        fails++; $display("FAIL cold_rstn e=%0d got=%b exp=%b", e, rstn_o, m);
      end
      checks++;
      if (ready_o !== (m == ALL)) begin
        fails++; $display("FAIL cold_ready e=%0d got=%b exp=%b", e, ready_o, (m == ALL));
      end
      checks++;
      if (lock_lost_o !== 1'b0) begin
        fails++; $display("FAIL cold_lock_lost e=%0d got=%b exp=0", e, lock_lost_o);
      end
    end
  endtask

  task automatic test_lock_glitch;
    logic [STAGES-1:0] m;
    int p, wl;
    for (int it = 0; it < 3; it++) begin
      p  = (it == 0) ? 5 : int'($urandom_range(1, LOCK_FILT - 1));
      wl = p + 3;  // p counted samples, one low sample, then a fresh count
      do_reset_release();
      for (int e = 0; e <= wl + LOCK_FILT + STAGES * HOLD_CYC + 3; e++) begin
        tick();
        m = exp_mask(e, wl);
        checks++;
        if (rstn_o !== m) begin
          fails++; $display("FAIL glitch_rstn p=%0d e=%0d got=%b exp=%b", p, e, rstn_o, m);
        end
        checks++;
        if (ready_o !== (m == ALL)) begin
          fails++; $display("FAIL glitch_ready p=%0d e=%0d got=%b exp=%b", p, e, ready_o, (m == ALL));
        end
        if (e == p)     pll_lock_i = 1'b0;
        if (e == p + 1) pll_lock_i = 1'b1;
      end
    end
  endtask

  // ends in RUN with lock_lost_o set
  task automatic test_lock_loss;
    logic [STAGES-1:0] m;
    logic ll;
    int d, r;
    for (int it = 0; it < 2; it++) begin
      d = int'($urandom_range(8, 70));
      r = d + int'($urandom_range(3, 8));
      do_reset_release();
      for (int e = 0; e <= r + 2 + LOCK_FILT + STAGES * HOLD_CYC + 3; e++) begin
        tick();
        if (e <= d + 2) begin
          m = exp_mask(e, 2); ll = 1'b0;
        end else begin
          m = exp_mask(e, r + 2); ll = 1'b1;
        end
        checks++;
        if (rstn_o !== m) begin
          fails++; $display("FAIL lockloss_rstn d=%0d e=%0d got=%b exp=%b", d, e, rstn_o, m);
        end
        checks++;
        if (ready_o !== (m == ALL)) begin
          fails++; $display("FAIL lockloss_ready d=%0d e=%0d got=%b exp=%b", d, e, ready_o, (m == ALL));
        end
        checks++;
        if (lock_lost_o !== ll) begin
          fails++; $display("FAIL lockloss_flag d=%0d e=%0d got=%b exp=%b", d, e, lock_lost_o, ll);
        end
        if (e == d) pll_lock_i = 1'b0;
        if (e == r) pll_lock_i = 1'b1;
      end
    end
  endtask

  // starts in RUN with lock_lost_o set: a lock loss re-enters RELEASE with
  // the flag still set, then sw_rst_i after stage 0 is out clears everything
  task automatic test_sw_rst;
    logic [STAGES-1:0] m;
    logic ll;
    int s;
    s = int'($urandom_range(30, 60));
    for (int e = 0; e <= s + 1 + LOCK_FILT + STAGES * HOLD_CYC + 3; e++) begin
      tick();
      if (e <= 2) begin
        m = ALL; ll = 1'b1;
      end else if (e <= s) begin
        m = exp_mask(e, 6); ll = 1'b1;
      end else begin
        m = exp_mask(e, s + 1); ll = 1'b0;
      end
      checks++;
      if (rstn_o !== m) begin
        fails++; $display("FAIL swrst_rstn s=%0d e=%0d got=%b exp=%b", s, e, rstn_o, m);
      end
      checks++;
      if (ready_o !== (m == ALL)) begin
        fails++; $display("FAIL swrst_ready s=%0d e=%0d got=%b exp=%b", s, e, ready_o, (m == ALL));
      end
      checks++;
      if (lock_lost_o !== ll) begin
        fails++; $display("FAIL swrst_flag s=%0d e=%0d got=%b exp=%b", s, e, lock_lost_o, ll);
      end
      if (e == 0) pll_lock_i = 1'b0;
      if (e == 4) pll_lock_i = 1'b1;
      sw_rst_i = (e == s);
    end
    sw_rst_i = 1'b0;
  endtask

  // starts in RUN with lock_lost_o clear
  task automatic test_simultaneous;
    logic [STAGES-1:0] m;
    logic ll;
    int d, r;
    d = int'($urandom_range(0, 5));
    r = d + int'($urandom_range(3, 8));
    for (int e = 0; e <= r + 2 + LOCK_FILT + STAGES * HOLD_CYC + 3; e++) begin
      tick();
      if (e <= d + 2) begin
        m = ALL; ll = 1'b0;
      end else begin
        m = exp_mask(e, r + 2); ll = 1'b1;
      end
      checks++;
      if (rstn_o !== m) begin
        fails++; $display("FAIL simul_rstn d=%0d e=%0d got=%b exp=%b", d, e, rstn_o, m);
      end
      checks++;
      if (lock_lost_o !== ll) begin
        fails++; $display("FAIL simul_flag d=%0d e=%0d got=%b exp=%b", d, e, lock_lost_o, ll);
      end
      if (e == d) pll_lock_i = 1'b0;
      if (e == r) pll_lock_i = 1'b1;
      sw_rst_i = (e == d + 2);
    end
    sw_rst_i = 1'b0;
  endtask

  // starts in RUN with lock_lost_o set
  task automatic test_async_reset;
    logic [STAGES-1:0] m;
    int a;
    a = int'($urandom_range(30, 60));
    for (int e = 0; e <= a; e++) begin
      tick();
      m = (e <= 2) ? ALL : exp_mask(e, 6);
      checks++;
      if (rstn_o !== m) begin
        fails++; $display("FAIL async_pre_rstn e=%0d got=%b exp=%b", e, rstn_o, m);
      end
      if (e == 0) pll_lock_i = 1'b0;
      if (e == 4) pll_lock_i = 1'b1;
    end
    #3;
    rstn_i = 1'b0;
    #1;
    checks++;
    if (rstn_o !== '0) begin
      fails++; $display("FAIL async_rstn got=%b exp=%b", rstn_o, {STAGES{1'b0}});
    end
    checks++;
    if (ready_o !== 1'b0) begin
      fails++; $display("FAIL async_ready got=%b exp=0", ready_o);
    end
    checks++;
    if (lock_lost_o !== 1'b0) begin
      fails++; $display("FAIL async_flag got=%b exp=0", lock_lost_o);
    end
    do_reset_release();
    for (int e = 0; e <= 2 + LOCK_FILT + STAGES * HOLD_CYC + 3; e++) begin
      tick();
      m = exp_mask(e, 2);
      checks++;
      if (rstn_o !== m) begin
        fails++; $display("FAIL async_restart_rstn e=%0d got=%b exp=%b", e, rstn_o, m);
      end
      checks++;
      if (ready_o !== (m == ALL)) begin
        fails++; $display("FAIL async_restart_ready e=%0d got=%b exp=%b", e, ready_o, (m == ALL));
      end
    end
  endtask

  initial begin
    rstn_i     = 1'b1;
    pll_lock_i = 1'b1;
    sw_rst_i   = 1'b0;
    #2;
    rstn_i = 1'b0;
    test_reset();
    test_cold_start();
    test_lock_glitch();
    test_lock_loss();
    test_sw_rst();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/red_pitaya_rst_seq.md
# red_pitaya_rst_seq

Power-on and run-time reset sequencer. It consumes the board-level global reset and the PLL lock indication, and releases `STAGES` active-low domain resets one at a time, in a fixed order, with a programmable gap between them. It sits between the clock/PLL block and the housekeeping, ADC/DAC and processing cores. All downstream resets are synchronous to `clk_i` and are pulled back on PLL lock loss or a software reset request.

## Interface
- `STAGES`, 3: number of sequenced reset outputs (1..8).
- `HOLD_CYC`, 16: clocks between successive stage releases (2..65535).
- `LOCK_FILT`, 8: consecutive synchronized-lock clocks required before sequencing starts (1..65535).
- `clk_i` in 1: sequencer clock, free-running from the PLL reference.
- `rstn_i` in 1: global reset. Fixed as asynchronous assert, active-low, single clock domain.
- `pll_lock_i` in 1: PLL lock, asynchronous to `clk_i`.
- `sw_rst_i` in 1: software reset request, single-cycle pulse, synchronous to `clk_i`.
- `rstn_o` out STAGES: domain resets, active-low, registered. Bit 0 is released first.
- `ready_o` out 1: high when all stages are released (state RUN).
- `lock_lost_o` out 1: sticky flag, set on lock loss after sequencing has started. Cleared by `rstn_i` or by `sw_rst_i`.

## Operation
- Reset values (`rstn_i` low): `rstn_o`=0, `ready_o`=0, `lock_lost_o`=0, state RESET, counters 0.
- `rstn_i` asserts asynchronously. Its deassertion passes through a 2-flop synchronizer (`rst_s`). `pll_lock_i` also passes through a 2-flop synchronizer (`lock_s`).
- States:
  - **RESET**: leave for WAIT_LOCK on the first clock with `rst_s`=1.
  - **WAIT_LOCK**:
    - `fcnt` increments while `lock_s`=1 and clears to 0 when `lock_s`=0.
    - When `fcnt` reaches `LOCK_FILT`, go to RELEASE with `stage`=0 and `hcnt`=0.
  - **RELEASE**:
    - `hcnt` increments every clock.
    - When `hcnt` reaches `HOLD_CYC`-1, the registered `rstn_o[stage]` goes to 1, `hcnt` goes to 0 and `stage` increments.
    - When the released bit is `STAGES`-1, go to RUN. `ready_o` rises on the same edge.
  - **RUN**: hold. `rstn_o` is all ones.
- Lock loss (`lock_s`=0) in RELEASE or RUN:
  - Next edge: `rstn_o`=0, `ready_o`=0, `lock_lost_o`=1, counters cleared, state WAIT_LOCK.
- `sw_rst_i`=1 in RELEASE or RUN:
  - Next edge: `rstn_o`=0, `ready_o`=0, `lock_lost_o`=0, state WAIT_LOCK.
  - Sequencing restarts once the filter passes again.
- `sw_rst_i` in RESET or WAIT_LOCK: only clears `lock_lost_o`.
- Simultaneous lock loss and `sw_rst_i`: lock loss wins, so `lock_lost_o`=1.
- `rstn_i` assertion in any state: immediate asynchronous return to reset values. The sequence restarts from RESET.
- Outputs only ever rise in stage order. Any drop clears all stages on the same edge.
- Counter widths: `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- `rstn_i` rising before edge n: `rst_s`=1 after edge n+1, WAIT_LOCK after edge n+2.
- `pll_lock_i` rising before edge m: `lock_s`=1 after edge m+1.
- With `lock_s` high from the first WAIT_LOCK cycle:
  - RELEASE is entered `LOCK_FILT` edges later.
  - `rstn_o[k]` rises (k+1)·`HOLD_CYC` edges after RELEASE entry.
- Lock loss to all `rstn_o` low: 3 edges from `pll_lock_i` falling (2 sync + 1 register).
- `sw_rst_i` to all `rstn_o` low: 1 edge.
- Glitch rule: a `lock_s` low pulse of 1 cycle in WAIT_LOCK restarts the filter count from 0.

## Structure
- `rst_seq_pkg`: state enum (RESET, WAIT_LOCK, RELEASE, RUN) and the `CNT_W` helper function.
- Sub-module `red_pitaya_sync2`: 2-flop synchronizer with parameterized reset value. It is instanced twice: `rstn_i` (reset value 0) and `pll_lock_i` (reset value 0).
- Single always_ff for the FSM and counters. `rstn_o` is driven from flops only.

## Test plan
- **Cold start**: `pll_lock_i`=1, release `rstn_i` at edge 0, defaults -> WAIT_LOCK at edge 2; `rstn_o` = 001 at edge 26, 011 at edge 42, 111 and `ready_o`=1 at edge 58.
- **Lock glitch during filter**: lock low for 1 cycle after 5 filter cycles -> filter restarts; `rstn_o[0]` is delayed by 6 extra cycles vs. cold start.
- **Lock loss in RUN**: drop `pll_lock_i` -> `rstn_o`=000, `ready_o`=0, `lock_lost_o`=1 three edges later. Restore lock -> full sequence replays; `lock_lost_o` stays 1.
- **`sw_rst_i` mid-RELEASE** (after stage 0 released) -> `rstn_o`=000 next edge, `lock_lost_o` cleared; re-release `rstn_o[0]` at LOCK_FILT+HOLD_CYC = 24 edges later.
- **Simultaneous `sw_rst_i` and lock loss** at the same `lock_s` fall -> `lock_lost_o`=1, outputs 000.
- **Async reset mid-RELEASE**: assert `rstn_i` between edges -> `rstn_o`=000 and `ready_o`=0 immediately, without waiting for a clock edge; the sequence restarts after release.
